// File: rtl/column_accumulator_if.sv
// rtl/column_accumulator_if.sv - Beat/result handshake bundle for column_accumulator
//
// Purpose: groups the column-beat input stream and the result output stream.
// Signals:
//   in_valid/in_ready/in_last : column beat handshake, in_last closes a group
//   O0..O14                    : column bit-vectors, every bit of Ok weighs 2^k
//   out_valid/out_ready        : result handshake
//   out_data                   : signed 32-bit group sum
//   out_count                  : beats in the group, saturating at 255
// Modports: master drives beats and consumes results, slave is the accumulator.

interface column_accumulator_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_last;
   logic [17:0] O0;
   logic [8:0]  O1;
   logic [26:0] O2;
   logic [17:0] O3;
   logic [35:0] O4;
   logic [26:0] O5;
   logic [44:0] O6;
   logic [35:0] O7;
   logic [35:0] O8;
   logic [35:0] O9;
   logic [35:0] O10;
   logic [17:0] O11;
   logic [17:0] O12;
   logic [8:0]  O13;
   logic [8:0]  O14;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [7:0]  out_count;

   modport master (
      output in_valid, in_last,
      output O0, O1, O2, O3, O4, O5, O6, O7, O8, O9, O10, O11, O12, O13, O14,
      output out_ready,
      input  in_ready, out_valid, out_data, out_count
   );

   modport slave (
      input  in_valid, in_last,
      input  O0, O1, O2, O3, O4, O5, O6, O7, O8, O9, O10, O11, O12, O13, O14,
      input  out_ready,
      output in_ready, out_valid, out_data, out_count
   );
endinterface

// File: rtl/column_accumulator.sv
// rtl/column_accumulator.sv - Two-stage weighted column popcount accumulator
//
// Purpose: each accepted beat is reduced to sum_k popcount(Ok)*2^k, truncated
// to 16 bits and sign-extended; beats are summed per group (closed by in_last)
// and the group sum plus beat count is presented on the result handshake.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : column_accumulator_if.slave (beat input, result output)
// Pipeline: stage 1 registers per-column popcounts, stage 2 accumulates and
// loads the result registers on the last beat. A pending, unconsumed result
// freezes the whole pipeline.

module column_accumulator (
   input logic                 clk,
   input logic                 reset,
   column_accumulator_if.slave bus
);

   function automatic logic [5:0] popcount45(input logic [44:0] v);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < 45; i++) begin
         n = n + {5'd0, v[i]};
      end
      return n;
   endfunction

   // Columns zero-extended to a common width so one popcount serves all.
   logic [44:0] col [15];
   assign col[0]  = {27'd0, bus.O0};
   assign col[1]  = {36'd0, bus.O1};
   assign col[2]  = {18'd0, bus.O2};
   assign col[3]  = {27'd0, bus.O3};
   assign col[4]  = {9'd0,  bus.O4};
   assign col[5]  = {18'd0, bus.O5};
   assign col[6]  = bus.O6;
   assign col[7]  = {9'd0,  bus.O7};
   assign col[8]  = {9'd0,  bus.O8};
   assign col[9]  = {9'd0,  bus.O9};
   assign col[10] = {9'd0,  bus.O10};
   assign col[11] = {27'd0, bus.O11};
   assign col[12] = {27'd0, bus.O12};
   assign col[13] = {36'd0, bus.O13};
   assign col[14] = {36'd0, bus.O14};

   logic [5:0] pc_d [15];
   for (genvar k = 0; k < 15; k++) begin : g_pc
      assign pc_d[k] = popcount45(col[k]);
   end

   logic [5:0]  pc_q [15];
   logic        s1_valid_q;
   logic        s1_last_q;
   logic [31:0] acc_q;
   logic [7:0]  cnt_q;
   logic        first_q;
   logic        out_valid_q;
   logic [31:0] out_data_q;
   logic [7:0]  out_count_q;

   logic        stall;
   logic [15:0] sum16;
   logic [31:0] dot;
   logic [31:0] acc_d;
   logic [7:0]  cnt_d;

   assign stall        = out_valid_q && !bus.out_ready;
   assign bus.in_ready = !stall;

   // Only the low 16 bits of the weighted sum are kept, so the sum is built
   // modulo 2^16 directly.
   always_comb begin
      sum16 = '0;
      for (int k = 0; k < 15; k++) begin
         sum16 = sum16 + ({10'd0, pc_q[k]} << k);
      end
   end

   assign dot   = {{16{sum16[15]}}, sum16};
   assign acc_d = first_q ? dot : acc_q + dot;
   assign cnt_d = first_q ? 8'd1 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 15; k++) begin
            pc_q[k] <= '0;
         end
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         first_q     <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
      end else if (!stall) begin
         s1_valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            for (int k = 0; k < 15; k++) begin
               pc_q[k] <= pc_d[k];
            end
            s1_last_q <= bus.in_last;
         end

         if (s1_valid_q) begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            first_q <= s1_last_q;
         end

         // A new result load wins over the consume of the previous one.
         if (s1_valid_q && s1_last_q) begin
            out_data_q  <= acc_d;
            out_count_q <= cnt_d;
            out_valid_q <= 1'b1;
         end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_count = out_count_q;

endmodule
